// File: rtl/pc_gen_pkg.sv
// Shared fetch-side definitions: chip-enable levels,
// branch flag level and default instruction address width.
package pc_gen_pkg;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic BRANCH       = 1'b1;
    localparam int unsigned INST_ADDR_W = 32;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch redirect/stall bundle between pipeline control and pc_gen.
// master: pc_gen (drives pc/ce/status); slave: pipeline/memory side.
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall_i;
    logic              if_ready_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_addr_i;
    logic              flush_i;
    logic [ADDR_W-1:0] flush_addr_i;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              redir_pend_o;
    logic              misalign_o;

    modport master (
        input  stall_i, if_ready_i,
        input  branch_flag_i, branch_target_addr_i,
        input  flush_i, flush_addr_i,
        output pc, ce, redir_pend_o, misalign_o
    );

    modport slave (
        output stall_i, if_ready_i,
        output branch_flag_i, branch_target_addr_i,
        output flush_i, flush_addr_i,
        input  pc, ce, redir_pend_o, misalign_o
    );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator: boot delay, sequential fetch, branch/flush
// redirect with a one-entry pending target. Ports: clk, rst (active-low), bus.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W     = INST_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int unsigned       INC        = 4,
    parameter int unsigned       BOOT_DELAY = 1
) (
    input logic      clk,
    input logic      rst,
    pc_gen_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              ce_q, ce_d;
    logic              mis_q, mis_d;
    logic              adv;

    assign adv = ce_q & bus.if_ready_i & ~bus.stall_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        ce_d    = ce_q;
        unique case (state_q)
            BOOT: begin
                // Redirects are ignored until the first fetch is issued.
                cnt_d = cnt_q + 4'd1;
                pc_d  = RESET_VEC;
                if (cnt_d == 4'(BOOT_DELAY)) begin
                    state_d = RUN;
                    ce_d    = CHIP_ENABLE;
                end
            end
            RUN, PEND: begin
                if (bus.flush_i) begin
                    pc_d    = bus.flush_addr_i;
                    pend_d  = '0;
                    state_d = RUN;
                end else if (bus.branch_flag_i == BRANCH) begin
                    if (adv) begin
                        pc_d    = bus.branch_target_addr_i;
                        pend_d  = '0;
                        state_d = RUN;
                    end else begin
                        // Newest target wins while fetch is blocked.
                        pend_d  = bus.branch_target_addr_i;
                        state_d = PEND;
                    end
                end else if (adv) begin
                    if (state_q == PEND) begin
                        pc_d    = pend_q;
                        pend_d  = '0;
                        state_d = RUN;
                    end else begin
                        pc_d = pc_q + ADDR_W'(INC);
                    end
                end
            end
            default: begin
                state_d = BOOT;
                cnt_d   = '0;
                pc_d    = RESET_VEC;
                pend_d  = '0;
                ce_d    = CHIP_DISABLE;
            end
        endcase
        mis_d = ce_d & (pc_d[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
            ce_q    <= CHIP_DISABLE;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            ce_q    <= ce_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.ce           = ce_q;
    assign bus.redir_pend_o = (state_q == PEND);
    assign bus.misalign_o   = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with BOOT_DELAY = 3.
// Drives inputs 1 time unit after each rising edge and checks there too.
module tb_pc_gen;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pc_gen_if #(.ADDR_W(32)) bus ();

    pc_gen #(
        .ADDR_W(32),
        .RESET_VEC(32'h0000_0000),
        .INC(4),
        .BOOT_DELAY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall_i              = 1'b0;
        bus.branch_flag_i        = 1'b0;
        bus.branch_target_addr_i = '0;
        bus.flush_i              = 1'b0;
        bus.flush_addr_i         = '0;
    endtask

    task automatic branch(input logic [31:0] t);
        bus.branch_flag_i        = 1'b1;
        bus.branch_target_addr_i = t;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle();
        bus.if_ready_i = 1'b1;
        #3;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_ce", 32'(bus.ce), 32'h0);
        chk("rst_pend", 32'(bus.redir_pend_o), 32'h0);
        chk("rst_mis", 32'(bus.misalign_o), 32'h0);
        tick();
        tick();
        rst = 1'b1;

        // boot: ce low for 3 cycles, then 0,4,8
        chk("boot_ce0", 32'(bus.ce), 32'h0);
        tick();
        chk("boot_ce1", 32'(bus.ce), 32'h0);
        tick();
        chk("boot_ce2", 32'(bus.ce), 32'h0);
        tick();
        chk("boot_ce3", 32'(bus.ce), 32'h1);
        chk("seq_pc0", bus.pc, 32'h0);
        tick();
        chk("seq_pc4", bus.pc, 32'h4);
        tick();
        chk("seq_pc8", bus.pc, 32'h8);

        // if_ready low holds pc
        bus.if_ready_i = 1'b0;
        tick();
        chk("hold_nrdy", bus.pc, 32'h8);
        bus.if_ready_i = 1'b1;

        // taken branch with advance
        branch(32'h100);
        tick();
        chk("br_100", bus.pc, 32'h100);
        branch(32'h2000);
        tick();
        chk("br_2000", bus.pc, 32'h2000);
        chk("br_nopend", 32'(bus.redir_pend_o), 32'h0);

        // stalled branches: newer target overwrites pending
        branch(32'h100);
        tick();
        bus.stall_i = 1'b1;
        branch(32'h2000);
        tick();
        chk("pend1_flag", 32'(bus.redir_pend_o), 32'h1);
        chk("pend1_pc", bus.pc, 32'h100);
        branch(32'h3000);
        tick();
        chk("pend2_flag", 32'(bus.redir_pend_o), 32'h1);
        chk("pend2_pc", bus.pc, 32'h100);
        idle();
        tick();
        chk("pend_apply", bus.pc, 32'h3000);
        chk("pend_clr", 32'(bus.redir_pend_o), 32'h0);
        tick();
        chk("pend_seq", bus.pc, 32'h3004);

        // flush beats branch and pending, even while stalled
        bus.stall_i = 1'b1;
        branch(32'h4000);
        tick();
        chk("pend3_flag", 32'(bus.redir_pend_o), 32'h1);
        bus.flush_i      = 1'b1;
        bus.flush_addr_i = 32'hBFC0_0380;
        branch(32'h2000);
        tick();
        chk("flush_pc", bus.pc, 32'hBFC0_0380);
        chk("flush_pend", 32'(bus.redir_pend_o), 32'h0);
        idle();
        tick();
        chk("flush_seq", bus.pc, 32'hBFC0_0384);

        // wrap and misalignment
        branch(32'hFFFF_FFFC);
        tick();
        chk("wrap_pre", bus.pc, 32'hFFFF_FFFC);
        idle();
        tick();
        chk("wrap_pc", bus.pc, 32'h0);
        branch(32'h1002);
        tick();
        chk("mis_pc", bus.pc, 32'h1002);
        chk("mis_flag", 32'(bus.misalign_o), 32'h1);
        branch(32'h2000);
        tick();
        chk("mis_clr", 32'(bus.misalign_o), 32'h0);

        // async reset while pending
        bus.stall_i = 1'b1;
        branch(32'h5000);
        tick();
        chk("pend4_flag", 32'(bus.redir_pend_o), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pc", bus.pc, 32'h0);
        chk("arst_ce", 32'(bus.ce), 32'h0);
        chk("arst_pend", 32'(bus.redir_pend_o), 32'h0);
        tick();
        rst = 1'b0;
        idle();

        // redirects ignored during boot
        bus.flush_i      = 1'b1;
        bus.flush_addr_i = 32'h8000;
        rst = 1'b1;
        tick();
        chk("boot2_ce1", 32'(bus.ce), 32'h0);
        chk("boot2_pc1", bus.pc, 32'h0);
        tick();
        tick();
        chk("boot2_ce", 32'(bus.ce), 32'h1);
        chk("boot2_pc", bus.pc, 32'h0);
        idle();
        tick();
        chk("boot2_seq", bus.pc, 32'h4);
        chk("boot2_nopend", 32'(bus.redir_pend_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
